// File: rtl/output_display_pkg.sv
// Shared types and constants for the output_display block: FSM states,
// 7-segment codes and the BCD sizing rule for the double-dabble converter.
package output_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    // Segment order is {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // log10(2) ~= 0.302, so this many nibbles hold any WIDTH-bit magnitude
    function automatic int bcd_digits(input int width);
        return (width * 302) / 1000 + 1;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/output_display_if.sv
// Bus-side and display-side signals of output_display; the host/bench holds
// the master view, the display block the slave view.
interface output_display_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic [WIDTH-1:0]  bus;
    logic              input_en;
    logic              clear;
    logic              signed_mode;
    logic [6:0]        display;
    logic [DIGITS-1:0] display_en;
    logic              neg;
    logic              overflow;
    logic              busy;

    modport master (
        output bus, input_en, clear, signed_mode,
        input  display, display_en, neg, overflow, busy
    );

    modport slave (
        input  bus, input_en, clear, signed_mode,
        output display, display_en, neg, overflow, busy
    );
endinterface

// File: rtl/output_display_bin_to_bcd_seq.sv
// Sequential double-dabble: i_start loads a binary value, WIDTH shift cycles
// follow, then o_done pulses for one cycle while o_bcd holds the result.
module bin_to_bcd_seq #(
    parameter int WIDTH      = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic [WIDTH-1:0]        i_bin,
    output logic [BCD_DIGITS*4-1:0] o_bcd,
    output logic                    o_last,
    output logic                    o_done
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0]        r_bin;
    logic [BCD_DIGITS*4-1:0] r_bcd;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_run;
    logic                    r_done;
    logic [BCD_DIGITS*4-1:0] w_adj;
    logic [BCD_DIGITS*4-1:0] w_bcd_next;
    logic [WIDTH-1:0]        w_bin_next;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
        {w_bcd_next, w_bin_next} = {w_adj, r_bin} << 1;
    end

    assign o_last = r_run && (r_cnt == CNT_W'(WIDTH - 1));
    assign o_done = r_done;
    assign o_bcd  = r_bcd;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else if (i_abort) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_bin  <= i_bin;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b1;
            r_done <= 1'b0;
        end else if (r_run) begin
            r_bin  <= w_bin_next;
            r_bcd  <= w_bcd_next;
            r_cnt  <= o_last ? '0 : r_cnt + CNT_W'(1);
            r_run  <= !o_last;
            r_done <= o_last;
        end else begin
            r_done <= 1'b0;
        end
    end

endmodule

// File: rtl/output_display.sv
// Output register with one-deep load queue, sequential BCD conversion and a
// multiplexed, leading-zero-blanked 7-segment scan driven from the system clock.
module output_display
    import output_display_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 1024
) (
    input  logic            clock,
    input  logic            reset_btn,
    output_display_if.slave dif
);
    localparam int BCD_DIGITS = bcd_digits(WIDTH);
    localparam int CNT_W      = $clog2(REFRESH_DIV);
    localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t                  r_state, w_next;
    logic                    w_start, w_last, w_done, w_load_pend;
    logic [WIDTH-1:0]        w_src_bus, w_mag;
    logic                    w_src_signed, w_src_neg;
    logic                    r_pend_valid, r_pend_signed;
    logic [WIDTH-1:0]        r_pend_bus;
    logic                    r_sign, r_neg, r_ovf;
    logic [BCD_DIGITS*4-1:0] w_bcd;
    logic [DIGITS*4-1:0]     r_digits, w_new_digits;
    logic                    w_new_ovf;
    logic [CNT_W-1:0]        r_refresh;
    logic [IDX_W-1:0]        r_idx;
    logic [3:0]              w_cur;
    logic                    w_upper_nz, w_blank;

    // A queued load, when present, takes precedence over the live bus at COMMIT
    assign w_load_pend  = (r_state == ST_COMMIT) && r_pend_valid;
    assign w_src_bus    = w_load_pend ? r_pend_bus : dif.bus;
    assign w_src_signed = w_load_pend ? r_pend_signed : dif.signed_mode;
    assign w_src_neg    = w_src_signed && w_src_bus[WIDTH-1];
    assign w_mag        = w_src_neg ? -w_src_bus : w_src_bus;

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        if (dif.clear) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (dif.input_en) begin
                    w_start = 1'b1;
                    w_next  = ST_SHIFT;
                end
                ST_SHIFT: if (w_last) w_next = ST_COMMIT;
                ST_COMMIT: begin
                    w_start = r_pend_valid || dif.input_en;
                    w_next  = w_start ? ST_SHIFT : ST_IDLE;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_btn) begin
        if (!reset_btn) r_state <= ST_IDLE;
        else            r_state <= w_next;
    end

    bin_to_bcd_seq #(.WIDTH(WIDTH), .BCD_DIGITS(BCD_DIGITS)) u_bin_to_bcd (
        .clk    (clock),
        .rst_n  (reset_btn),
        .i_start(w_start),
        .i_abort(dif.clear),
        .i_bin  (w_mag),
        .o_bcd  (w_bcd),
        .o_last (w_last),
        .o_done (w_done)
    );

    always_ff @(posedge clock or negedge reset_btn) begin
        if (!reset_btn) begin
            r_pend_valid  <= 1'b0;
            r_pend_signed <= 1'b0;
            r_pend_bus    <= '0;
            r_sign        <= 1'b0;
        end else if (dif.clear) begin
            r_pend_valid  <= 1'b0;
            r_pend_signed <= 1'b0;
            r_pend_bus    <= '0;
            r_sign        <= 1'b0;
        end else begin
            if (w_start) r_sign <= w_src_neg;
            // A COMMIT with an empty queue consumes input_en directly as the next load
            if (w_load_pend || (r_state == ST_SHIFT)) begin
                if (dif.input_en) begin
                    r_pend_valid  <= 1'b1;
                    r_pend_bus    <= dif.bus;
                    r_pend_signed <= dif.signed_mode;
                end else if (w_load_pend) begin
                    r_pend_valid  <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_new_digits = '0;
        w_new_ovf    = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (d < BCD_DIGITS) w_new_digits[4*d +: 4] = w_bcd[4*d +: 4];
        end
        for (int d = DIGITS; d < BCD_DIGITS; d++) begin
            if (w_bcd[4*d +: 4] != 4'd0) w_new_ovf = 1'b1;
        end
    end

    // NOTE: the digit store is a handful of flops, so it is reset like any register rather than treated as RAM.
    always_ff @(posedge clock or negedge reset_btn) begin
        if (!reset_btn) begin
            r_digits <= '0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (dif.clear) begin
            r_digits <= '0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_done) begin
            r_digits <= w_new_digits;
            r_neg    <= r_sign;
            r_ovf    <= w_new_ovf;
        end
    end

    // Scan runs free of the FSM and of clear
    always_ff @(posedge clock or negedge reset_btn) begin
        if (!reset_btn) begin
            r_refresh <= '0;
            r_idx     <= '0;
        end else if (r_refresh == CNT_W'(REFRESH_DIV - 1)) begin
            r_refresh <= '0;
            r_idx     <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_refresh <= r_refresh + CNT_W'(1);
        end
    end

    always_comb begin
        w_cur      = 4'd0;
        w_upper_nz = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (IDX_W'(d) == r_idx) w_cur = r_digits[4*d +: 4];
            if ((IDX_W'(d) >= r_idx) && (r_digits[4*d +: 4] != 4'd0)) w_upper_nz = 1'b1;
        end
        w_blank     = (r_idx != '0) && !w_upper_nz;
        dif.display = r_ovf ? SEG_DASH : (w_blank ? SEG_BLANK : seg_of(w_cur));
    end

    assign dif.display_en = DIGITS'(1) << r_idx;
    assign dif.neg        = r_neg;
    assign dif.overflow   = r_ovf;
    assign dif.busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_output_display.sv
// Directed bench for output_display: an 8-bit and a 16-bit instance, both
// with a short refresh period so a full digit scan fits between commits.
module tb_output_display;

    localparam logic [6:0] SEG_REF [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    localparam logic [6:0] BLK = 7'h00;
    localparam logic [6:0] DSH = 7'h40;

    logic clock = 1'b0;
    logic reset_btn = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [6:0] seen [3];

    always #5 clock = ~clock;

    output_display_if #(.WIDTH(8),  .DIGITS(3)) if8 ();
    output_display_if #(.WIDTH(16), .DIGITS(3)) if16 ();

    output_display #(.WIDTH(8), .DIGITS(3), .REFRESH_DIV(2)) u_dut8 (
        .clock(clock), .reset_btn(reset_btn), .dif(if8)
    );
    output_display #(.WIDTH(16), .DIGITS(3), .REFRESH_DIV(2)) u_dut16 (
        .clock(clock), .reset_btn(reset_btn), .dif(if16)
    );

    task automatic load8(input logic [7:0] v, input logic sm);
        if8.bus = v; if8.signed_mode = sm; if8.input_en = 1'b1;
        @(negedge clock);
        if8.input_en = 1'b0;
    endtask

    task automatic load16(input logic [15:0] v, input logic sm);
        if16.bus = v; if16.signed_mode = sm; if16.input_en = 1'b1;
        @(negedge clock);
        if16.input_en = 1'b0;
    endtask

    // One full scan (3 digits x 2 cycles); remember the segments seen per digit
    task automatic scan8();
        for (int d = 0; d < 3; d++) seen[d] = 'x;
        repeat (6) begin
            @(negedge clock);
            for (int d = 0; d < 3; d++) if (if8.display_en == 3'(1 << d)) seen[d] = if8.display;
        end
    endtask

    task automatic scan16();
        for (int d = 0; d < 3; d++) seen[d] = 'x;
        repeat (6) begin
            @(negedge clock);
            for (int d = 0; d < 3; d++) if (if16.display_en == 3'(1 << d)) seen[d] = if16.display;
        end
    endtask

    task automatic test_reset();
        n_vec += 6;
        if (if8.display_en !== 3'b001) begin n_err++; $display("FAIL reset_en: got %b, expected 001", if8.display_en); end
        if (if8.display !== 7'h3F) begin n_err++; $display("FAIL reset_seg: got %h, expected 3f", if8.display); end
        if (if8.neg !== 1'b0) begin n_err++; $display("FAIL reset_neg: got %b, expected 0", if8.neg); end
        if (if8.overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b, expected 0", if8.overflow); end
        if (if8.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, expected 0", if8.busy); end
        if (if16.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy16: got %b, expected 0", if16.busy); end
    endtask

    typedef struct packed {
        logic [7:0]      val;
        logic            sm;
        logic            neg;
        logic [2:0][6:0] seg;
    } vec_t;

    task automatic test_convert();
        vec_t tbl [7];
        tbl[0] = {8'hFF, 1'b0, 1'b0, SEG_REF[2], SEG_REF[5], SEG_REF[5]};
        tbl[1] = {8'h80, 1'b1, 1'b1, SEG_REF[1], SEG_REF[2], SEG_REF[8]};
        tbl[2] = {8'hFB, 1'b1, 1'b1, BLK,        BLK,        SEG_REF[5]};
        tbl[3] = {8'h80, 1'b0, 1'b0, SEG_REF[1], SEG_REF[2], SEG_REF[8]};
        tbl[4] = {8'h64, 1'b0, 1'b0, SEG_REF[1], SEG_REF[0], SEG_REF[0]};
        tbl[5] = {8'h7F, 1'b1, 1'b0, SEG_REF[1], SEG_REF[2], SEG_REF[7]};
        tbl[6] = {8'h00, 1'b1, 1'b0, BLK,        BLK,        SEG_REF[0]};
        for (int v = 0; v < 7; v++) begin
            load8(tbl[v].val, tbl[v].sm);
            n_vec++;
            if (if8.busy !== 1'b1) begin n_err++; $display("FAIL conv%0d_busy_e0: got %b, expected 1", v, if8.busy); end
            repeat (8) @(negedge clock);
            n_vec++;
            if (if8.busy !== 1'b1) begin n_err++; $display("FAIL conv%0d_busy_e8: got %b, expected 1", v, if8.busy); end
            @(negedge clock);
            n_vec += 3;
            if (if8.busy !== 1'b0) begin n_err++; $display("FAIL conv%0d_busy_e9: got %b, expected 0", v, if8.busy); end
            if (if8.neg !== tbl[v].neg) begin n_err++; $display("FAIL conv%0d_neg: got %b, expected %b", v, if8.neg, tbl[v].neg); end
            if (if8.overflow !== 1'b0) begin n_err++; $display("FAIL conv%0d_ovf: got %b, expected 0", v, if8.overflow); end
            scan8();
            for (int d = 0; d < 3; d++) begin
                n_vec++;
                if (seen[d] !== tbl[v].seg[d]) begin
                    n_err++; $display("FAIL conv%0d_digit%0d: got %h, expected %h", v, d, seen[d], tbl[v].seg[d]);
                end
            end
        end
    endtask

    task automatic test_overflow16();
        logic [15:0]     vals [3] = '{16'd1000, 16'hFC18, 16'd999};
        logic            sms  [3] = '{1'b0, 1'b1, 1'b0};
        logic            ovfs [3] = '{1'b1, 1'b1, 1'b0};
        logic            negs [3] = '{1'b0, 1'b1, 1'b0};
        logic [6:0]      segs [3] = '{DSH, DSH, SEG_REF[9]};
        for (int v = 0; v < 3; v++) begin
            load16(vals[v], sms[v]);
            repeat (16) @(negedge clock);
            n_vec++;
            if (if16.busy !== 1'b1) begin n_err++; $display("FAIL w16_%0d_busy_e16: got %b, expected 1", v, if16.busy); end
            @(negedge clock);
            n_vec += 3;
            if (if16.busy !== 1'b0) begin n_err++; $display("FAIL w16_%0d_busy_e17: got %b, expected 0", v, if16.busy); end
            if (if16.overflow !== ovfs[v]) begin n_err++; $display("FAIL w16_%0d_ovf: got %b, expected %b", v, if16.overflow, ovfs[v]); end
            if (if16.neg !== negs[v]) begin n_err++; $display("FAIL w16_%0d_neg: got %b, expected %b", v, if16.neg, negs[v]); end
            scan16();
            for (int d = 0; d < 3; d++) begin
                n_vec++;
                if (seen[d] !== segs[v]) begin
                    n_err++; $display("FAIL w16_%0d_digit%0d: got %h, expected %h", v, d, seen[d], segs[v]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp12 [3] = '{SEG_REF[2], SEG_REF[1], BLK};
        logic [6:0] exp56 [3] = '{SEG_REF[6], SEG_REF[5], BLK};
        load8(8'd12, 1'b0);
        @(negedge clock);
        if8.bus = 8'd34; if8.input_en = 1'b1;
        @(negedge clock);
        if8.input_en = 1'b0;
        @(negedge clock);
        if8.bus = 8'd56; if8.input_en = 1'b1;
        @(negedge clock);
        if8.input_en = 1'b0;
        repeat (5) @(negedge clock);
        n_vec++;
        if (if8.busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_e9: got %b, expected 1", if8.busy); end
        scan8();
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (seen[d] !== exp12[d]) begin n_err++; $display("FAIL b2b_first_digit%0d: got %h, expected %h", d, seen[d], exp12[d]); end
        end
        repeat (2) @(negedge clock);
        n_vec++;
        if (if8.busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_e17: got %b, expected 1", if8.busy); end
        @(negedge clock);
        n_vec++;
        if (if8.busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_e18: got %b, expected 0", if8.busy); end
        scan8();
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (seen[d] !== exp56[d]) begin n_err++; $display("FAIL b2b_second_digit%0d: got %h, expected %h", d, seen[d], exp56[d]); end
        end
    endtask

    task automatic test_clear();
        logic [6:0] exp0 [3] = '{SEG_REF[0], BLK, BLK};
        logic [6:0] exp3 [3] = '{SEG_REF[3], BLK, BLK};
        load8(8'hFB, 1'b1);
        repeat (9) @(negedge clock);
        load8(8'hFF, 1'b0);
        if8.bus = 8'h22; if8.input_en = 1'b1;
        @(negedge clock);
        if8.input_en = 1'b0;
        @(negedge clock);
        if8.bus = 8'h11; if8.input_en = 1'b1; if8.clear = 1'b1;
        @(negedge clock);
        if8.input_en = 1'b0; if8.clear = 1'b0;
        n_vec += 3;
        if (if8.busy !== 1'b0) begin n_err++; $display("FAIL clr_busy: got %b, expected 0", if8.busy); end
        if (if8.neg !== 1'b0) begin n_err++; $display("FAIL clr_neg: got %b, expected 0", if8.neg); end
        if (if8.overflow !== 1'b0) begin n_err++; $display("FAIL clr_ovf: got %b, expected 0", if8.overflow); end
        repeat (10) @(negedge clock);
        n_vec++;
        if (if8.busy !== 1'b0) begin n_err++; $display("FAIL clr_idle_hold: got %b, expected 0", if8.busy); end
        scan8();
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (seen[d] !== exp0[d]) begin n_err++; $display("FAIL clr_digit%0d: got %h, expected %h", d, seen[d], exp0[d]); end
        end
        // A surviving queued load would keep the FSM busy past this commit
        load8(8'h03, 1'b0);
        repeat (9) @(negedge clock);
        n_vec++;
        if (if8.busy !== 1'b0) begin n_err++; $display("FAIL clr_pend_empty: got busy %b, expected 0", if8.busy); end
        scan8();
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (seen[d] !== exp3[d]) begin n_err++; $display("FAIL clr_reload_digit%0d: got %h, expected %h", d, seen[d], exp3[d]); end
        end
    endtask

    task automatic test_async_reset();
        load8(8'hFB, 1'b1);
        repeat (9) @(negedge clock);
        load8(8'hFF, 1'b0);
        repeat (3) @(negedge clock);
        reset_btn = 1'b0;
        #1;
        n_vec += 5;
        if (if8.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, expected 0", if8.busy); end
        if (if8.neg !== 1'b0) begin n_err++; $display("FAIL rst_neg: got %b, expected 0", if8.neg); end
        if (if8.overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b, expected 0", if8.overflow); end
        if (if8.display_en !== 3'b001) begin n_err++; $display("FAIL rst_en: got %b, expected 001", if8.display_en); end
        if (if8.display !== 7'h3F) begin n_err++; $display("FAIL rst_seg: got %h, expected 3f", if8.display); end
        @(negedge clock);
        reset_btn = 1'b1;
        repeat (12) @(negedge clock);
        n_vec++;
        if (if8.busy !== 1'b0) begin n_err++; $display("FAIL rst_no_resume: got %b, expected 0", if8.busy); end
    endtask

    initial begin
        if8.bus = '0;  if8.input_en = 1'b0;  if8.clear = 1'b0;  if8.signed_mode = 1'b0;
        if16.bus = '0; if16.input_en = 1'b0; if16.clear = 1'b0; if16.signed_mode = 1'b0;
        repeat (2) @(negedge clock);
        reset_btn = 1'b1;
        #1;
        test_reset();
        test_convert();
        test_overflow16();
        test_back_to_back();
        test_clear();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion within 200000 time units");
        $fatal(1);
    end

endmodule
